// File: rtl/timer_arbiter.sv
// Shares the single 1 Hz seconds timer between two requesters with round-robin
// fairness, counts elapsed seconds from flash toggles and pulses done on completion.
module timer_arbiter #(
  parameter int SEC_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [SEC_W-1:0] i_dur0,
  input  logic [SEC_W-1:0] i_dur1,
  input  logic             i_flash_in,
  output logic             o_timer_en,
  output logic             o_grant0,
  output logic             o_grant1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [SEC_W-1:0] o_sec_left,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic             r_flash_q;
  logic             r_last;
  logic             w_last_n;
  logic             r_timer_en;
  logic             w_timer_en_n;
  logic             r_grant0;
  logic             w_grant0_n;
  logic             r_grant1;
  logic             w_grant1_n;
  logic             r_done0;
  logic             w_done0_n;
  logic             r_done1;
  logic             w_done1_n;
  logic [SEC_W-1:0] r_sec_left;
  logic [SEC_W-1:0] w_sec_left_n;
  logic             r_busy;
  logic             w_busy_n;

  logic             w_tick;
  logic             w_pick1;
  logic [SEC_W-1:0] w_dur;
  logic             w_granted_req;

  // req1 wins when alone, or on a tie when req0 was served last
  assign w_tick        = i_flash_in ^ r_flash_q;
  assign w_pick1       = i_req1 & (~i_req0 | ~r_last);
  assign w_dur         = w_pick1 ? i_dur1 : i_dur0;
  assign w_granted_req = (r_grant0 & i_req0) | (r_grant1 & i_req1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_flash_q  <= 1'b0;
      r_last     <= 1'b1;
      r_timer_en <= 1'b0;
      r_grant0   <= 1'b0;
      r_grant1   <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_sec_left <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_flash_q  <= i_flash_in;
      r_last     <= w_last_n;
      r_timer_en <= w_timer_en_n;
      r_grant0   <= w_grant0_n;
      r_grant1   <= w_grant1_n;
      r_done0    <= w_done0_n;
      r_done1    <= w_done1_n;
      r_sec_left <= w_sec_left_n;
      r_busy     <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_last_n     = r_last;
    w_timer_en_n = r_timer_en;
    w_grant0_n   = r_grant0;
    w_grant1_n   = r_grant1;
    w_done0_n    = 1'b0;
    w_done1_n    = 1'b0;
    w_sec_left_n = r_sec_left;
    w_busy_n     = r_busy;

    case (r_state)
      ST_IDLE: begin
        if (i_req0 || i_req1) begin
          w_grant0_n   = ~w_pick1;
          w_grant1_n   = w_pick1;
          w_last_n     = w_pick1;
          w_sec_left_n = w_dur;
          w_busy_n     = 1'b1;
          if (w_dur != '0) begin
            w_state_n    = ST_RUN;
            w_timer_en_n = 1'b1;
          end else begin
            w_state_n = ST_DONE;
            w_done0_n = ~w_pick1;
            w_done1_n = w_pick1;
          end
        end
      end

      ST_RUN: begin
        // abort beats a simultaneous final tick, so no done pulse is issued
        if (!w_granted_req) begin
          w_state_n    = ST_IDLE;
          w_grant0_n   = 1'b0;
          w_grant1_n   = 1'b0;
          w_timer_en_n = 1'b0;
          w_sec_left_n = '0;
          w_busy_n     = 1'b0;
        end else if (w_tick) begin
          if (r_sec_left > SEC_W'(1)) begin
            w_sec_left_n = r_sec_left - SEC_W'(1);
          end else begin
            w_state_n    = ST_DONE;
            w_sec_left_n = '0;
            w_timer_en_n = 1'b0;
            w_grant0_n   = 1'b0;
            w_grant1_n   = 1'b0;
            w_done0_n    = r_grant0;
            w_done1_n    = r_grant1;
          end
        end
      end

      ST_DONE: begin
        // one cycle with the timer disabled lets the clock driver clear flash
        w_state_n    = ST_IDLE;
        w_grant0_n   = 1'b0;
        w_grant1_n   = 1'b0;
        w_timer_en_n = 1'b0;
        w_sec_left_n = '0;
        w_busy_n     = 1'b0;
      end

      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  assign o_timer_en = r_timer_en;
  assign o_grant0   = r_grant0;
  assign o_grant1   = r_grant1;
  assign o_done0    = r_done0;
  assign o_done1    = r_done1;
  assign o_sec_left = r_sec_left;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed scoreboard bench for timer_arbiter: expected output words are queued
// as stimulus is applied and popped/compared one clock later.
module tb_timer_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0;
  logic       req1;
  logic [3:0] dur0;
  logic [3:0] dur1;
  logic       flash;
  logic       timerEn;
  logic       grant0;
  logic       grant1;
  logic       done0;
  logic       done1;
  logic [3:0] secLeft;
  logic       busy;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int       total = 0;
  int       bad   = 0;

  localparam logic [9:0] ZERO = 10'b0;

  always #5 clk = ~clk;

  timer_arbiter #(.SEC_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req0     (req0),
    .i_req1     (req1),
    .i_dur0     (dur0),
    .i_dur1     (dur1),
    .i_flash_in (flash),
    .o_timer_en (timerEn),
    .o_grant0   (grant0),
    .o_grant1   (grant1),
    .o_done0    (done0),
    .o_done1    (done1),
    .o_sec_left (secLeft),
    .o_busy     (busy)
  );

  // packs {grant0, grant1, done0, done1, timer_en, busy, sec_left}
  function automatic logic [9:0] ex(input logic g0, input logic g1, input logic d0,
                                    input logic d1, input logic te, input logic bz,
                                    input logic [3:0] sl);
    return {g0, g1, d0, d1, te, bz, sl};
  endfunction

  task automatic applyStimulus(input string tag, input logic [9:0] exp);
    sbEntry_t e;
    e.tag = tag;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input bit waitEdge);
    sbEntry_t   e;
    logic [9:0] obs;
    if (waitEdge) begin
      @(posedge clk);
      #1;
    end
    e   = sbQ.pop_front();
    obs = {grant0, grant1, done0, done1, timerEn, busy, secLeft};
    total++;
    assert (obs === e.exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  task automatic step(input string tag, input logic [9:0] exp);
    applyStimulus(tag, exp);
    checkOutput(1'b1);
  endtask

  task automatic hold(input string tag, input logic [9:0] exp, input int n);
    for (int i = 0; i < n; i++) step(tag, exp);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    dur0  = 4'd0;
    dur1  = 4'd0;
    flash = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("reset", ZERO);
    rst = 1'b0;
    step("idle", ZERO);

    // full 3 s interval for req0
    req0 = 1'b1;
    dur0 = 4'd3;
    step("s1_grant", ex(1, 0, 0, 0, 1, 1, 4'd3));
    hold("s1_wait3", ex(1, 0, 0, 0, 1, 1, 4'd3), 9);
    flash = 1'b1;
    step("s1_sec2", ex(1, 0, 0, 0, 1, 1, 4'd2));
    hold("s1_wait2", ex(1, 0, 0, 0, 1, 1, 4'd2), 9);
    flash = 1'b0;
    step("s1_sec1", ex(1, 0, 0, 0, 1, 1, 4'd1));
    hold("s1_wait1", ex(1, 0, 0, 0, 1, 1, 4'd1), 9);
    flash = 1'b1;
    step("s1_done", ex(0, 0, 1, 0, 0, 1, 4'd0));
    req0  = 1'b0;
    flash = 1'b0;
    step("s1_idle", ZERO);

    // tie after reset goes to req0, then req1 takes its turn
    rst = 1'b1;
    step("s2_rst", ZERO);
    rst  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    dur0 = 4'd1;
    dur1 = 4'd2;
    step("s2_g0", ex(1, 0, 0, 0, 1, 1, 4'd1));
    flash = 1'b1;
    step("s2_done0", ex(0, 0, 1, 0, 0, 1, 4'd0));
    flash = 1'b0;
    step("s2_gap", ZERO);
    step("s2_g1", ex(0, 1, 0, 0, 1, 1, 4'd2));
    flash = 1'b1;
    step("s2_g1_sec1", ex(0, 1, 0, 0, 1, 1, 4'd1));
    flash = 1'b0;
    step("s2_done1", ex(0, 0, 0, 1, 0, 1, 4'd0));
    req1 = 1'b0;
    step("s2_gap2", ZERO);
    step("s2_g0b", ex(1, 0, 0, 0, 1, 1, 4'd1));
    req0 = 1'b0;
    step("s2_abort", ZERO);

    // zero duration: grant and done together, timer never enabled
    req1 = 1'b1;
    dur1 = 4'd0;
    step("s3_zero", ex(0, 1, 0, 1, 0, 1, 4'd0));
    req1 = 1'b0;
    hold("s3_after", ZERO, 2);

    // abort after two ticks of a 5 s interval
    req0 = 1'b1;
    dur0 = 4'd5;
    step("s4_grant", ex(1, 0, 0, 0, 1, 1, 4'd5));
    flash = 1'b1;
    step("s4_sec4", ex(1, 0, 0, 0, 1, 1, 4'd4));
    hold("s4_wait4", ex(1, 0, 0, 0, 1, 1, 4'd4), 2);
    flash = 1'b0;
    step("s4_sec3", ex(1, 0, 0, 0, 1, 1, 4'd3));
    req0 = 1'b0;
    step("s4_abort", ZERO);
    hold("s4_nodone", ZERO, 3);

    // abort coinciding with the final tick
    req0 = 1'b1;
    dur0 = 4'd1;
    step("s5_grant", ex(1, 0, 0, 0, 1, 1, 4'd1));
    flash = 1'b1;
    req0  = 1'b0;
    step("s5_abort_tick", ZERO);
    flash = 1'b0;
    step("s5_after", ZERO);

    // asynchronous reset mid-run, then the tie goes back to req0
    req1 = 1'b1;
    dur1 = 4'd2;
    step("s6_grant", ex(0, 1, 0, 0, 1, 1, 4'd2));
    rst = 1'b1;
    #1;
    applyStimulus("s6_async", ZERO);
    checkOutput(1'b0);
    step("s6_held", ZERO);
    rst  = 1'b0;
    req0 = 1'b1;
    dur0 = 4'd2;
    step("s6_tie", ex(1, 0, 0, 0, 1, 1, 4'd2));
    req0 = 1'b0;
    req1 = 1'b0;
    step("s6_end", ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
